// File: rtl/timer_bus_master.sv
// timer_bus_master: turns single-beat commands into CPU-side bus cycles for a
// 6530-style interval timer (write count/prescaler, read count, read status,
// wait for interrupt) and returns exactly one response per command.
// Every output is a flop loaded from the next-state decode, so the pins change
// in the same cycle that the state they belong to becomes current.
// Optional build macro: TIMER_BUS_MASTER_IRQ_PIN_EN. When defined, op 11 waits
// on the irq_n pin instead of polling the status register.
module timer_bus_master #(
  parameter int unsigned POLL_W     = 16,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [1:0] cmd_prescale,
  input  logic       cmd_irq_en,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       bus_we_n,
  output logic [2:0] bus_a,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_oe,
  input  logic       irq_n
);

  localparam logic [1:0] OP_WR    = 2'b00;
  localparam logic [1:0] OP_RDCNT = 2'b01;
  localparam logic [1:0] OP_RDST  = 2'b10;
  // status read address; side-effect free, so it doubles as the idle address
  localparam logic [2:0] A_IDLE   = 3'b001;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD_ADDR, RD_CAPT, POLL_ADDR, POLL_CAPT, RESP
`ifdef TIMER_BUS_MASTER_IRQ_PIN_EN
    , WAIT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        pre_q, pre_d;
  logic              ien_q, ien_d;
  logic [POLL_W-1:0] cnt_q, cnt_d;
  logic [7:0]        rsp_data_d;
  logic              rsp_err_d;
  logic              bus_we_n_d;
  logic [2:0]        bus_a_d;
  logic [7:0]        bus_wdata_d;
  logic              accept;

  // handshake uses the registered ready so nothing is taken while in reset
  assign accept = cmd_valid & cmd_ready;

`ifdef TIMER_BUS_MASTER_IRQ_PIN_EN
  logic irq_n_q;
  // register the interrupt pin once before the wait state looks at it
  always_ff @(posedge clk) begin
    if (!rst_n) irq_n_q <= 1'b1;
    else        irq_n_q <= irq_n;
  end
`else
  logic unused_irq_n;
  assign unused_irq_n = irq_n;
`endif

  // next-state, response and bus decode
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    pre_d      = pre_q;
    ien_d      = ien_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          pre_d  = cmd_prescale;
          ien_d  = cmd_irq_en;
          case (cmd_op)
            OP_WR:             state_d = WR;
            OP_RDCNT, OP_RDST: state_d = RD_ADDR;
            default: begin
              cnt_d = '0;
`ifdef TIMER_BUS_MASTER_IRQ_PIN_EN
              state_d = WAIT;
`else
              state_d = POLL_ADDR;
`endif
            end
          endcase
        end
      end
      WR: begin
        rsp_data_d = 8'h00;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end
      RD_ADDR: state_d = RD_CAPT;
      RD_CAPT: begin
        // the timer's OE only matters for the count register
        rsp_data_d = bus_rdata;
        rsp_err_d  = (op_q == OP_RDCNT) ? ~bus_oe : 1'b0;
        state_d    = RESP;
      end
      POLL_ADDR: state_d = POLL_CAPT;
      POLL_CAPT: begin
        if (!bus_rdata[7]) begin
          rsp_data_d = bus_rdata;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == POLL_LAST) begin
          rsp_data_d = 8'hFF;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = POLL_ADDR;
        end
      end
`ifdef TIMER_BUS_MASTER_IRQ_PIN_EN
      WAIT: begin
        if (!irq_n_q) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == POLL_LAST) begin
          rsp_data_d = 8'hFF;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // bus pins follow the state being entered; anything not driving is idle
    bus_we_n_d  = 1'b1;
    bus_a_d     = A_IDLE;
    bus_wdata_d = 8'h00;
    case (state_d)
      WR: begin
        bus_we_n_d  = 1'b0;
        bus_a_d     = {ien_d, pre_d};
        bus_wdata_d = data_d;
      end
      RD_ADDR: bus_a_d = (op_d == OP_RDCNT) ? {ien_d, 2'b00} : A_IDLE;
      default: ;
    endcase
  end

  // state, command latch and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      data_q    <= 8'h00;
      pre_q     <= 2'b00;
      ien_q     <= 1'b0;
      cnt_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
      bus_we_n  <= 1'b1;
      bus_a     <= A_IDLE;
      bus_wdata <= 8'h00;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      pre_q     <= pre_d;
      ien_q     <= ien_d;
      cnt_q     <= cnt_d;
      cmd_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      bus_we_n  <= bus_we_n_d;
      bus_a     <= bus_a_d;
      bus_wdata <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_timer_bus_master.sv
// tb_timer_bus_master: randomized commands against a cycle-level reference of
// the timer bus sequencer, with a timer-side stimulus that only presents the
// intended read data in the capture cycles.
module tb_timer_bus_master;

  localparam int LIM = 4;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [1:0] cmd_prescale;
  logic       cmd_irq_en;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       bus_we_n;
  logic [2:0] bus_a;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_oe;
  logic       irq_n;

  int n_chk = 0;
  int n_pass = 0;

  timer_bus_master #(.POLL_W(16), .POLL_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_prescale(cmd_prescale), .cmd_irq_en(cmd_irq_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bus_we_n(bus_we_n), .bus_a(bus_a), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_oe(bus_oe), .irq_n(irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // timer side for cycle c after accept: read data appears only at c==2,
  // status bit7 goes low from poll npoll onward; all else is noise
  task automatic drive_slave(input logic [1:0] op, input int c, input logic [7:0] rdv,
                             input logic oe, input int npoll);
    bus_rdata = 8'($urandom);
    bus_oe    = 1'($urandom);
    if ((op == 2'b01 || op == 2'b10) && c == 2) begin
      bus_rdata = rdv;
      bus_oe    = oe;
    end
    if (op == 2'b11 && (c % 2) == 0) begin
      if (c / 2 >= npoll) bus_rdata = {1'b0, rdv[6:0]};
      else                bus_rdata[7] = 1'b1;
    end
  endtask

  // one command from an idle negedge to the negedge after its handshake
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [1:0] pre,
                         input logic ien, input logic [7:0] rdv, input logic oe,
                         input int npoll, input int stall);
    int c, lat, exp_lat, we_lo, we_cyc, polls;
    logic [2:0] we_a, a1;
    logic [7:0] we_d, exp_d, hold_d;
    logic exp_e, hold_e, busy_ok, stall_ok;
    case (op)
      2'b00: begin exp_lat = 2; exp_d = 8'h00; exp_e = 1'b0; end
      2'b01: begin exp_lat = 3; exp_d = rdv;   exp_e = ~oe;  end
      2'b10: begin exp_lat = 3; exp_d = rdv;   exp_e = 1'b0; end
      default: begin
        polls   = (npoll > LIM) ? LIM : npoll;
        exp_lat = 2 * polls + 1;
        exp_d   = (npoll > LIM) ? 8'hFF : {1'b0, rdv[6:0]};
        exp_e   = (npoll > LIM);
      end
    endcase
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_prescale = pre; cmd_irq_en = ien;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data = 8'($urandom); cmd_prescale = 2'($urandom);
    cmd_irq_en = 1'($urandom); cmd_op = 2'($urandom);
    c = 1; lat = 0; we_lo = 0; we_cyc = 0; busy_ok = 1'b1;
    a1 = 3'b000; we_a = 3'b000; we_d = 8'h00;
    while (lat == 0 && c <= 2 * LIM + 6) begin
      drive_slave(op, c, rdv, oe, npoll);
      rsp_ready = 1'($urandom);
      @(negedge clk);
      if (c == 1) a1 = bus_a;
      if (!bus_we_n) begin we_lo++; we_cyc = c; we_a = bus_a; we_d = bus_wdata; end
      if (rsp_valid) lat = c;
      else begin
        if (cmd_ready) busy_ok = 1'b0;
        @(posedge clk); #1;
        c++;
      end
    end
    rsp_ready = 1'b0;
    chk("latency", lat, exp_lat);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", rsp_err, exp_e);
    chk("busy_not_ready", busy_ok, 1);
    chk("we_pulses", we_lo, (op == 2'b00) ? 1 : 0);
    chk("rsp_bus_idle", {bus_we_n, bus_a, bus_wdata}, {1'b1, 3'b001, 8'h00});
    if (op == 2'b00) begin
      chk("wr_cycle", we_cyc, 1);
      chk("wr_addr", we_a, {ien, pre});
      chk("wr_data", we_d, d);
    end else begin
      chk("addr_phase", a1, (op == 2'b01) ? {ien, 2'b00} : 3'b001);
    end
    if (lat == 0) return;
    hold_d = rsp_data; hold_e = rsp_err; stall_ok = 1'b1;
    repeat (stall) begin
      @(posedge clk); #1;
      bus_rdata = 8'($urandom); bus_oe = 1'($urandom);
      @(negedge clk);
      if (!rsp_valid || rsp_data !== hold_d || rsp_err !== hold_e || cmd_ready ||
          !bus_we_n || bus_a !== 3'b001 || bus_wdata !== 8'h00) stall_ok = 1'b0;
    end
    if (stall > 0) chk("stall_stable", stall_ok, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_ready", cmd_ready, 1);
  endtask

  // back-to-back commands with rsp_ready held high
  task automatic tput(input logic [1:0] op, input int ncyc, input int exp_acc);
    int acc, lo, k;
    acc = 0; lo = 0; k = 0;
    cmd_op = op; cmd_valid = 1'b1; rsp_ready = 1'b1; bus_oe = 1'b1;
    cmd_data = 8'h5A; cmd_prescale = 2'b10; cmd_irq_en = 1'b0;
    repeat (ncyc) begin
      if (cmd_ready) acc++;
      if (!bus_we_n) lo++;
      @(posedge clk);
      @(negedge clk);
      bus_rdata = 8'($urandom);
    end
    cmd_valid = 1'b0;
    while (!(cmd_ready && !rsp_valid) && k < 20) begin @(negedge clk); k++; end
    rsp_ready = 1'b0;
    chk("tput_accepts", acc, exp_acc);
    chk("tput_we_lows", lo, (op == 2'b00) ? exp_acc : 0);
    chk("tput_drain", k < 20, 1);
  endtask

  // reset while the read is in its capture cycle
  task automatic reset_mid_read();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_irq_en = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; bus_rdata = 8'hA5; bus_oe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {cmd_ready, rsp_valid, rsp_data, rsp_err, bus_we_n, bus_a, bus_wdata},
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'b001, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", cmd_ready, 1);
    chk("rst_no_rsp", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int op, np;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    cmd_prescale = 2'b00; cmd_irq_en = 1'b0; rsp_ready = 1'b0;
    bus_rdata = 8'h00; bus_oe = 1'b0; irq_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {cmd_ready, rsp_valid, rsp_data, rsp_err, bus_we_n, bus_a, bus_wdata},
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'b001, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    run_cmd(2'b00, 8'h10, 2'b01, 1'b1, 8'h00, 1'b0, 0, 0);
    run_cmd(2'b01, 8'h00, 2'b00, 1'b1, 8'h3C, 1'b1, 0, 0);
    run_cmd(2'b01, 8'h00, 2'b00, 1'b0, 8'h3C, 1'b0, 0, 0);
    run_cmd(2'b10, 8'h00, 2'b11, 1'b1, 8'h47, 1'b1, 0, 1);
    run_cmd(2'b11, 8'h00, 2'b00, 1'b0, 8'h15, 1'b1, 3, 0);
    run_cmd(2'b11, 8'h00, 2'b00, 1'b0, 8'h80, 1'b1, 99, 0);
    run_cmd(2'b01, 8'h00, 2'b00, 1'b1, 8'hC3, 1'b1, 0, 5);
    reset_mid_read();

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      np = int'($urandom_range(1, LIM + 2));
      run_cmd(2'(op), 8'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
              1'($urandom), np, int'($urandom_range(0, 3)));
    end

    tput(2'b00, 30, 10);
    tput(2'b01, 32, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
